// File: rtl/puf_verify_pkg.sv
// puf_verify_pkg: shared widths, read count and FSM states for puf_verifier.
// Defining PUF_VERIFY_MAJORITY_EN selects three reads per verification instead of one.
package puf_verify_pkg;
    localparam int CHALL_W = 8;
    localparam int HD_W    = 4;
`ifdef PUF_VERIFY_MAJORITY_EN
    localparam int NUM_READS = 3;
`else
    localparam int NUM_READS = 1;
`endif
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMPARE, S_DONE} state_t;
endpackage

// File: rtl/popcount8.sv
// popcount8: combinational Hamming weight of an 8-bit word.
module popcount8
    import puf_verify_pkg::*;
(
    input  logic [CHALL_W-1:0] i_data,
    output logic [HD_W-1:0]    o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < CHALL_W; i++) o_count = o_count + HD_W'(i_data[i]);
    end
endmodule

// File: rtl/puf_verifier.sv
// puf_verifier: issues a challenge to a serialized PUF and checks its response against an enrolled value.
// Macro PUF_VERIFY_MAJORITY_EN enables three reads combined by bitwise 2-of-3 majority.
module puf_verifier
    import puf_verify_pkg::*;
#(
    parameter int HD_MAX         = 1,
    parameter int TIMEOUT_CYCLES = 1023
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CHALL_W-1:0] chall,
    input  logic [CHALL_W-1:0] expected,
    output logic               puf_en,
    output logic [CHALL_W-1:0] puf_chall,
    input  logic [CHALL_W-1:0] puf_response,
    input  logic               puf_ready,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [HD_W-1:0]    hd
);
    state_t             r_state, w_next;
    logic [15:0]        r_cnt;
    logic [CHALL_W-1:0] r_chall, r_exp, w_resp;
    logic [CHALL_W-1:0] r_resp [NUM_READS];
    logic [HD_W-1:0]    r_hd, w_hd;
    logic               r_pass, r_timeout, w_tmo, w_last;

    // r_cnt holds the WAIT cycles already elapsed, so +1 counts the current one
    assign w_tmo = (r_cnt + 16'd1) == 16'(TIMEOUT_CYCLES);

`ifdef PUF_VERIFY_MAJORITY_EN
    logic [1:0] r_rd;
    assign w_last = r_rd == 2'(NUM_READS - 1);
    assign w_resp = (r_resp[0] & r_resp[1]) | (r_resp[0] & r_resp[2]) | (r_resp[1] & r_resp[2]);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd <= '0;
            for (int i = 0; i < NUM_READS; i++) r_resp[i] <= '0;
        end else if (r_state == S_IDLE) begin
            r_rd <= '0;
        end else if (r_state == S_WAIT && puf_ready) begin
            r_resp[r_rd] <= puf_response;
            r_rd         <= r_rd + 2'd1;
        end
    end
`else
    assign w_last = 1'b1;
    assign w_resp = r_resp[0];
    always_ff @(posedge clk) begin
        if (rst) r_resp[0] <= '0;
        else if (r_state == S_WAIT && puf_ready) r_resp[0] <= puf_response;
    end
`endif

    popcount8 u_popcount (
        .i_data  (w_resp ^ r_exp),
        .o_count (w_hd)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = start ? S_ISSUE : S_IDLE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT:    w_next = puf_ready ? (w_last ? S_COMPARE : S_ISSUE) : (w_tmo ? S_DONE : S_WAIT);
            S_COMPARE: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_chall   <= '0;
            r_exp     <= '0;
            r_hd      <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT) ? r_cnt + 16'd1 : '0;
            if (r_state == S_IDLE && start) begin
                r_chall   <= chall;
                r_exp     <= expected;
                r_hd      <= '0;
                r_pass    <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (r_state == S_WAIT && !puf_ready && w_tmo) begin
                r_timeout <= 1'b1;
                r_pass    <= 1'b0;
                r_hd      <= '0;
            end
            if (r_state == S_COMPARE) begin
                r_hd   <= w_hd;
                r_pass <= 32'(w_hd) <= HD_MAX;
            end
        end
    end

    assign puf_en    = r_state == S_ISSUE;
    assign busy      = r_state != S_IDLE;
    assign done      = r_state == S_DONE;
    assign puf_chall = r_chall;
    assign pass      = r_pass;
    assign hd        = r_hd;
    assign timeout   = r_timeout;
endmodule
